pipelined_mantissa_addsub: RTL and testbench
============================================

// Module: pipelined_mantissa_addsub
// PURPOSE
//  Parametrised, pipelined mantissa adder/subtractor for the floating-point adder datapath.
//  Splits the MANT_W-bit add into STAGES chunks, registering the chunk carry between stages.
//  Adds subtract mode with sign/magnitude output, plus zero and leading-zero outputs for normalisation.
//  Uses a valid/ready handshake with whole-pipeline stall.
//  Sits between the exponent-align stage and the normalise/round stage.
// PARAMETERS
//  MANT_W  24  mantissa width incl. hidden bit; must be divisible by STAGES
//  STAGES  3   pipeline depth = number of carry chunks; CHUNK = MANT_W/STAGES
//  LZC_W   $clog2(MANT_W+1)  width of leading-zero count (derived, do not override)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept a beat this cycle
//  a          in   MANT_W   aligned mantissa A
//  b          in   MANT_W   aligned mantissa B
//  sub        in   1        1: compute A-B; 0: compute A+B+cin
//  cin        in   1        carry-in, add mode only (ignored when sub=1)
//  out_valid  out  1        result beat valid
//  out_ready  in   1        downstream accepts result
//  sum        out  MANT_W   add: low MANT_W bits of sum; sub: |A-B|
//  carry      out  1        add: carry out of bit MANT_W-1; sub: always 0
//  neg        out  1        sub: 1 if A<B; add: always 0
//  zero       out  1        sum==0
//  lzc        out  LZC_W    leading zeros of sum from MSB; MANT_W when zero=1
// BEHAVIOUR
//  - Reset: every stage valid bit, out_valid, sum, carry, neg, zero and lzc = 0 on the first clk edge with rst=1.
//    In-flight beats are discarded. in_ready = 1 in the cycle after reset deasserts.
//  - Accept: a beat enters on the clk edge where in_valid && in_ready.
//  - Stall: adv = !out_valid || out_ready; in_ready = adv.
//    When adv=0, all stage registers hold their contents; there are no bubbles to squeeze.
//  - Latency: a beat accepted at edge N shows out_valid=1 after edge N+STAGES when no stall occurs.
//    Throughput is 1 beat/clk.
//  - Operand prep: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
//  - Stage k (0..STAGES-1) adds chunk k of a and b_eff with the carry from stage k-1 (c0 for k=0).
//    It registers the chunk sum and carry-out.
//    Upper chunks are carried down the pipe unmodified (operand skew); lower results ride along.
//  - Final comb (after the last register): raw = {chunks}, co = last carry.
//    Add mode: sum = raw, carry = co, neg = 0.
//    Sub mode: co=1 -> sum = raw, neg = 0; co=0 -> sum = ~raw+1 (two's complement), neg = 1. carry = 0.
//    zero = (sum==0); lzc = count of leading 0s in sum.
//    All five are registered with out_valid (STAGES counts this output register as the last stage).
//    Outputs are stable while out_valid && !out_ready.
//  - Boundaries:
//    A==B in sub -> sum=0, zero=1, neg=0, lzc=MANT_W.
//    All-ones + 1 in add -> sum=0, carry=1, zero=1.
//    Bubbles (in_valid=0) propagate as stage valid=0; datapath registers may still update.
//    rst has priority over every other event on the same edge, including accept/stall.
//    Simultaneous accept and output handshake on the same edge is legal and loses no beat.
// STRUCTURE
//  - Shared header fp_defs.vh: MANT_W default, LZC_W function/macro, chunk-index macros.
//  - Sub-module mantissa_add_stage (CHUNK bits + carry in, registered sum/carry/valid, enable=adv).
//    Instantiate STAGES times with generate.
//  - Top holds the operand prep, the skew registers, the negate/zero/lzc output logic and the handshake.
// TESTING (MANT_W=24, STAGES=3)
//  1. add: a=0x800000, b=0x800000, cin=0, out_ready=1 -> after 3 clks sum=0x000000, carry=1, zero=1, lzc=24.
//  2. sub: a=0x400000, b=0x100000 -> sum=0x300000, neg=0, lzc=2; then a=0x100000, b=0x400000 -> sum=0x300000, neg=1.
//  3. carry ripple across chunks: a=0x00FFFF, b=0x000001, cin=0 -> sum=0x010000, carry=0;
//     add a=0xFFFFFF, b=0, cin=1 -> sum=0, carry=1.
//  4. back-to-back 5 beats with out_ready low for 4 clks mid-stream -> in_ready drops the same cycle;
//     all 5 results in order, none duplicated or lost.
//  5. sub A==B (0x5A5A5A) -> zero=1, neg=0, lzc=24;
//     sub mode with cin=1 gives the identical result (cin ignored).
//  6. assert rst while 3 beats are in flight -> next cycle out_valid=0, all outputs 0;
//     a fresh beat after reset returns the correct result after 3 clks.

Source files
------------

// File: rtl/pipelined_mantissa_addsub_pkg.sv
// Shared defaults and helpers for the pipelined mantissa adder/subtractor.
package pipelined_mantissa_addsub_pkg;

  localparam int unsigned MantWDefault  = 24;
  localparam int unsigned StagesDefault = 3;

  // Leading zeros of the low w bits of v; returns w when they are all zero.
  function automatic int unsigned clz(input logic [63:0] v, input int unsigned w);
    int unsigned n;
    logic        found;
    n     = 0;
    found = 1'b0;
    for (int i = int'(w) - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/pipelined_mantissa_addsub_stage.sv
// One carry chunk of the pipelined adder: adds a chunk with carry-in and registers the result.
module pipelined_mantissa_addsub_stage #(
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_carry,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_carry,
  output logic             o_valid
);

  logic [CHUNK:0]   w_add;
  logic [CHUNK-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;

  assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      {r_carry, r_sum} <= w_add;
      r_valid          <= i_valid;
    end
  end

  assign o_sum   = r_sum;
  assign o_carry = r_carry;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipelined_mantissa_addsub.sv
// Pipelined mantissa add/subtract with sign-magnitude result, zero flag and leading-zero count.
module pipelined_mantissa_addsub
  import pipelined_mantissa_addsub_pkg::*;
#(
  parameter int unsigned MANT_W = MantWDefault,
  parameter int unsigned STAGES = StagesDefault,
  localparam int unsigned LZC_W = $clog2(MANT_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  input  logic              sub,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] sum,
  output logic              carry,
  output logic              neg,
  output logic              zero,
  output logic [LZC_W-1:0]  lzc
);

  localparam int unsigned CHUNK = MANT_W / STAGES;

  logic              w_adv;
  logic [MANT_W-1:0] w_a   [STAGES+1];
  logic [MANT_W-1:0] w_b   [STAGES+1];
  logic [MANT_W-1:0] w_res [STAGES+1];
  logic              w_c   [STAGES+1];
  logic              w_v   [STAGES+1];
  logic              w_sub [STAGES+1];
  logic [CHUNK-1:0]  w_chunk_sum [STAGES];

  logic [MANT_W-1:0] w_sum;
  logic              w_carry;
  logic              w_neg;
  logic [LZC_W-1:0]  w_lzc;

  logic              r_out_valid;
  logic [MANT_W-1:0] r_sum;
  logic              r_carry;
  logic              r_neg;
  logic              r_zero;
  logic [LZC_W-1:0]  r_lzc;

  // Whole-pipeline stall: everything advances only when the output slot frees up.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  assign w_a[0]   = a;
  assign w_b[0]   = sub ? ~b : b;
  assign w_c[0]   = sub ? 1'b1 : cin;
  assign w_sub[0] = sub;
  assign w_v[0]   = in_valid;
  assign w_res[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [MANT_W-1:0] r_a;
    logic [MANT_W-1:0] r_b;
    logic [MANT_W-1:0] r_res;
    logic              r_sub;
    logic [MANT_W-1:0] w_res_next;

    pipelined_mantissa_addsub_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_valid (w_v[k]),
      .i_a     (w_a[k][k*CHUNK +: CHUNK]),
      .i_b     (w_b[k][k*CHUNK +: CHUNK]),
      .i_carry (w_c[k]),
      .o_sum   (w_chunk_sum[k]),
      .o_carry (w_c[k+1]),
      .o_valid (w_v[k+1])
    );

    // Operand skew and finished low chunks travel alongside; no reset needed on data.
    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_a   <= w_a[k];
        r_b   <= w_b[k];
        r_res <= w_res[k];
        r_sub <= w_sub[k];
      end
    end

    always_comb begin
      w_res_next                    = r_res;
      w_res_next[k*CHUNK +: CHUNK] = w_chunk_sum[k];
    end

    assign w_a[k+1]   = r_a;
    assign w_b[k+1]   = r_b;
    assign w_sub[k+1] = r_sub;
    assign w_res[k+1] = w_res_next;
  end

  // No carry out of A + ~B + 1 means A < B: negate to get the magnitude.
  always_comb begin
    w_sum   = w_res[STAGES];
    w_carry = w_c[STAGES];
    w_neg   = 1'b0;
    if (w_sub[STAGES]) begin
      w_carry = 1'b0;
      if (!w_c[STAGES]) begin
        w_sum = -w_res[STAGES];
        w_neg = 1'b1;
      end
    end
  end

  assign w_lzc = LZC_W'(clz(64'(w_sum), MANT_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_neg       <= 1'b0;
      r_zero      <= 1'b0;
      r_lzc       <= '0;
    end else if (w_adv) begin
      r_out_valid <= w_v[STAGES];
      r_sum       <= w_sum;
      r_carry     <= w_carry;
      r_neg       <= w_neg;
      r_zero      <= (w_sum == '0);
      r_lzc       <= w_lzc;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign neg       = r_neg;
  assign zero      = r_zero;
  assign lzc       = r_lzc;

endmodule

// File: tb/tb_pipelined_mantissa_addsub.sv
// Self-checking bench for pipelined_mantissa_addsub (MANT_W=24, STAGES=3).
module tb_pipelined_mantissa_addsub;

  typedef struct packed {
    logic [23:0] sum;
    logic        carry;
    logic        neg;
    logic        zero;
    logic [4:0]  lzc;
  } res_t;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic        sub;
    logic        cin;
    res_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] sum;
  logic        carry;
  logic        neg;
  logic        zero;
  logic [4:0]  lzc;

  int total = 0;
  int bad   = 0;

  pipelined_mantissa_addsub #(
    .MANT_W (24),
    .STAGES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .neg       (neg),
    .zero      (zero),
    .lzc       (lzc)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: plain integer add/subtract and bit-length for the zero count.
  function automatic res_t model(input logic [23:0] ma, input logic [23:0] mb,
                                 input logic msub, input logic mcin);
    res_t        r;
    logic [24:0] t;
    logic [23:0] v;
    int          n;
    r = '0;
    if (!msub) begin
      t       = {1'b0, ma} + {1'b0, mb} + 25'(mcin);
      r.sum   = t[23:0];
      r.carry = t[24];
    end else if (ma >= mb) begin
      r.sum = ma - mb;
    end else begin
      r.sum = mb - ma;
      r.neg = 1'b1;
    end
    r.zero = (r.sum == 24'd0);
    n = 24;
    v = r.sum;
    while (v != 24'd0) begin
      v = v >> 1;
      n--;
    end
    r.lzc = 5'(n);
    return r;
  endfunction

  // Drive one cycle, sample mid-cycle, then advance past the next rising edge.
  task automatic step(input logic iv, input logic [23:0] ia, input logic [23:0] ib,
                      input logic isub, input logic icin, input logic ordy,
                      output logic acc, output logic hs, output logic ov, output logic rdy,
                      output res_t o);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sub       = isub;
    cin       = icin;
    out_ready = ordy;
    #4;
    ov  = out_valid;
    rdy = in_ready;
    hs  = out_valid && ordy;
    acc = iv && in_ready;
    o   = '{sum: sum, carry: carry, neg: neg, zero: zero, lzc: lzc};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, sum, carry, neg, zero, lzc} !== '0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b sum=%h c=%b n=%b z=%b lzc=%0d want all 0",
               out_valid, sum, carry, neg, zero, lzc);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_latency();
    int   lat;
    res_t o;
    res_t e;
    e = '{sum: 24'h000000, carry: 1'b1, neg: 1'b0, zero: 1'b1, lzc: 5'd24};
    in_valid = 1'b1;
    a = 24'h800000;
    b = 24'h800000;
    sub = 1'b0;
    cin = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL add_latency: got %0d clks want 3", lat);
    end
    o = '{sum: sum, carry: carry, neg: neg, zero: zero, lzc: lzc};
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL add_overflow: got %h want %h", o, e);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_single_beat: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_directed_vectors();
    vec_t vt[$];
    int   q[$];
    int   idx;
    int   k;
    logic acc, hs, ov, rdy;
    res_t o;
    vt.push_back('{24'h400000, 24'h100000, 1'b1, 1'b0, '{24'h300000, 1'b0, 1'b0, 1'b0, 5'd2}});
    vt.push_back('{24'h100000, 24'h400000, 1'b1, 1'b0, '{24'h300000, 1'b0, 1'b1, 1'b0, 5'd2}});
    vt.push_back('{24'h00FFFF, 24'h000001, 1'b0, 1'b0, '{24'h010000, 1'b0, 1'b0, 1'b0, 5'd7}});
    vt.push_back('{24'hFFFFFF, 24'h000000, 1'b0, 1'b1, '{24'h000000, 1'b1, 1'b0, 1'b1, 5'd24}});
    vt.push_back('{24'h5A5A5A, 24'h5A5A5A, 1'b1, 1'b0, '{24'h000000, 1'b0, 1'b0, 1'b1, 5'd24}});
    vt.push_back('{24'h5A5A5A, 24'h5A5A5A, 1'b1, 1'b1, '{24'h000000, 1'b0, 1'b0, 1'b1, 5'd24}});
    vt.push_back('{24'h000000, 24'hFFFFFF, 1'b1, 1'b0, '{24'hFFFFFF, 1'b0, 1'b1, 1'b0, 5'd0}});
    vt.push_back('{24'h123456, 24'h654321, 1'b0, 1'b1, '{24'h777778, 1'b0, 1'b0, 1'b0, 5'd1}});
    vt.push_back('{24'h400000, 24'h100000, 1'b1, 1'b1, '{24'h300000, 1'b0, 1'b0, 1'b0, 5'd2}});
    idx = 0;
    for (int cyc = 0; cyc < 200 && (idx < vt.size() || q.size() != 0); cyc++) begin
      if (idx < vt.size())
        step(1'b1, vt[idx].a, vt[idx].b, vt[idx].sub, vt[idx].cin, 1'b1, acc, hs, ov, rdy, o);
      else
        step(1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1, acc, hs, ov, rdy, o);
      if (hs) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL directed_extra: got %h want no output", o);
        end else begin
          k = q.pop_front();
          if (o !== vt[k].e) begin
            bad++;
            $display("FAIL directed[%0d]: got %h want %h", k, o, vt[k].e);
          end
        end
      end
      if (acc) begin
        q.push_back(idx);
        idx++;
      end
    end
    total++;
    if (idx < vt.size() || q.size() != 0) begin
      bad++;
      $display("FAIL directed_timeout: got sent=%0d pending=%0d want %0d 0",
               idx, q.size(), vt.size());
    end
  endtask

  task automatic test_back_to_back();
    res_t        q[$];
    res_t        e;
    res_t        o;
    res_t        prev_o;
    logic        prev_stall;
    logic        acc, hs, ov, rdy, ordy;
    logic [23:0] ra, rb;
    logic        rs;
    int          sent, got;
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    prev_o = '0;
    ra = 24'($urandom);
    rb = 24'($urandom);
    rs = 1'($urandom);
    for (int cyc = 0; cyc < 100 && (sent < 5 || q.size() != 0); cyc++) begin
      ordy = !(cyc >= 4 && cyc < 8);
      step(sent < 5, ra, rb, rs, 1'b0, ordy, acc, hs, ov, rdy, o);
      total++;
      if (rdy !== (ordy || !ov)) begin
        bad++;
        $display("FAIL b2b_in_ready[%0d]: got %b want %b", cyc, rdy, ordy || !ov);
      end
      if (prev_stall) begin
        total++;
        if (!ov || o !== prev_o) begin
          bad++;
          $display("FAIL b2b_hold[%0d]: got v=%b %h want v=1 %h", cyc, ov, o, prev_o);
        end
      end
      prev_stall = ov && !ordy;
      prev_o = o;
      if (hs) begin
        got++;
        total++;
        e = (q.size() != 0) ? q.pop_front() : 'x;
        if (o !== e) begin
          bad++;
          $display("FAIL b2b_result[%0d]: got %h want %h", got, o, e);
        end
      end
      if (acc) begin
        q.push_back(model(ra, rb, rs, 1'b0));
        sent++;
        ra = 24'($urandom);
        rb = 24'($urandom);
        rs = 1'($urandom);
      end
    end
    total++;
    if (got != 5 || q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got %0d results pending=%0d want 5 0", got, q.size());
    end
  endtask

  task automatic test_reset_in_flight();
    res_t q[$];
    res_t e;
    res_t o;
    logic acc, hs, ov, rdy;
    int   acc_step, hs_step;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 24'hABC000 + 24'(i), 24'h000111, 1'b0, 1'b0, 1'b1, acc, hs, ov, rdy, o);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    a = 24'h0F0F0F;
    b = 24'h0F0F0F;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, sum, carry, neg, zero, lzc} !== '0) begin
      bad++;
      $display("FAIL rst_flight_clear: got valid=%b sum=%h c=%b n=%b z=%b lzc=%0d want all 0",
               out_valid, sum, carry, neg, zero, lzc);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    acc_step = -1;
    hs_step = -1;
    for (int s = 0; s < 30 && (acc_step < 0 || q.size() != 0); s++) begin
      step(acc_step < 0, 24'h000123, 24'h000456, 1'b0, 1'b0, 1'b1, acc, hs, ov, rdy, o);
      if (hs) begin
        total++;
        e = (q.size() != 0) ? q.pop_front() : 'x;
        if (o !== e) begin
          bad++;
          $display("FAIL rst_flight_result: got %h want %h", o, e);
        end
        hs_step = s;
      end
      if (acc) begin
        q.push_back(model(24'h000123, 24'h000456, 1'b0, 1'b0));
        acc_step = s;
      end
    end
    total++;
    if (acc_step < 0 || hs_step - acc_step != 4 || q.size() != 0) begin
      bad++;
      $display("FAIL rst_flight_latency: got acc=%0d out=%0d pending=%0d want out=acc+4",
               acc_step, hs_step, q.size());
    end
  endtask

  task automatic test_random();
    res_t        q[$];
    res_t        e;
    res_t        o;
    logic        acc, hs, ov, rdy, iv, ordy, rs, rc;
    logic [23:0] ra, rb;
    int          sent, got;
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 4000 && (sent < 300 || q.size() != 0); cyc++) begin
      iv = (sent < 300) && ($urandom_range(3) != 0);
      ra = 24'($urandom);
      rb = ($urandom_range(7) == 0) ? ra : 24'($urandom);
      if ($urandom_range(15) == 0) ra = 24'hFFFFFF;
      rs = 1'($urandom);
      rc = 1'($urandom);
      ordy = ($urandom_range(3) != 0);
      step(iv, ra, rb, rs, rc, ordy, acc, hs, ov, rdy, o);
      if (hs) begin
        got++;
        total++;
        e = (q.size() != 0) ? q.pop_front() : 'x;
        if (o !== e) begin
          bad++;
          $display("FAIL random[%0d]: got %h want %h", got, o, e);
        end
      end
      if (acc) begin
        q.push_back(model(ra, rb, rs, rc));
        sent++;
      end
    end
    total++;
    if (sent != 300 || q.size() != 0) begin
      bad++;
      $display("FAIL random_drain: got sent=%0d pending=%0d want 300 0", sent, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_directed_vectors();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
